data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Responder end of the CPU's `memory_bus` load/store interface: accepts single read/write dispatches from the execute stage, performs byte/halfword/word accesses against an internal block-RAM data memory, and returns right-justified load data with a completion pulse. It drives `busy` so the CPU stalls its memory stage exactly while a request is in flight. One outstanding request at a time; no queuing.

## Interface
- `DEPTH`, 4096: data memory size in 32-bit words; power of two.
- `READ_LATENCY`, 2: BRAM read pipeline depth in cycles; ≥1.
- `BASE_ADDR`, 32'h0000_0000: byte address mapped to word 0; must be `DEPTH*4`-aligned.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `addr` in 32: byte address of the request.
- `mem_width` in 2: access size, `mem::BYTE` (8 b), `mem::WORD` (16 b), `mem::DWORD` (32 b).
- `dispatch_read` in 1: load request strobe, sampled when `busy`=0.
- `dispatch_write` in 1: store request strobe, sampled when `busy`=0.
- `write_data` in 32: store data, right-justified; upper bits ignored for BYTE/WORD.
- `busy` out 1: request in flight; new dispatches are ignored.
- `read_data` out 32: load result, right-justified, zero-extended. The CPU performs sign extension.
- `data_valid` out 1: one-cycle pulse when `read_data` holds a completed load.
- `access_err` out 1: one-cycle pulse on a rejected request.

## Operation
- FSM states: IDLE, READ_WAIT, READ_DONE, WRITE_COMMIT.
- IDLE: if `dispatch_read` xor `dispatch_write` is set and the request is legal, latch `addr`, `mem_width` and `write_data`.
  - Read: go to READ_WAIT with the latency counter = `READ_LATENCY`-1.
  - Write: go to WRITE_COMMIT.
- A request is illegal if any of these holds:
  - `addr` is outside `[BASE_ADDR, BASE_ADDR+DEPTH*4)`.
  - WORD access with `addr[0]`=1.
  - DWORD access with `addr[1:0]`≠0.
  - Both strobes are asserted together.
  - `mem_width` is the unused encoding.
- An illegal request leaves the FSM in IDLE. The following cycle `access_err` pulses. For an illegal read, `data_valid` also pulses in that cycle with `read_data`=0, so the CPU never hangs. Memory is unchanged.
- READ_WAIT: decrement the counter. When it reaches 0, go to READ_DONE.
- READ_DONE: extract the lane and go to IDLE.
  - BYTE: `word[8*addr[1:0] +: 8]`.
  - WORD: `word[16*addr[1] +: 16]`.
  - DWORD: the whole word.
- WRITE_COMMIT: write the BRAM using byte enables, then go to IDLE.
  - BYTE enables `4'b0001 << addr[1:0]`, with data replicated ×4.
  - WORD enables `4'b0011 << 2*addr[1]`, with data replicated ×2.
  - DWORD enables `4'b1111`.
  - No read-modify-write.
- `read_data` holds its value until the next load completes. Stores do not change it.
- Word index = `(addr-BASE_ADDR) >> 2`, truncated to `$clog2(DEPTH)` bits.

## Timing
- Reset values: `busy`=0, `data_valid`=0, `access_err`=0, `read_data`=0, FSM=IDLE. Memory contents are not cleared.
- Reset asserted mid-operation:
  - Outputs go to their reset values immediately (asynchronously).
  - An in-flight read is discarded.
  - A write still in WRITE_COMMIT is cancelled and memory is unchanged.
- Dispatch sampled at the rising edge ending cycle N with `busy`=0 (this is cycle 0 of the request).
- Read:
  - `busy`=1 for cycles N+1 … N+`READ_LATENCY`+1.
  - In cycle N+`READ_LATENCY`+2: `busy`=0, `data_valid`=1, `read_data` valid.
  - Latency is `READ_LATENCY`+2 cycles from dispatch (4 at the default).
- Write:
  - `busy`=1 in cycle N+1 only.
  - The BRAM write takes effect at the edge ending N+1.
  - A new dispatch can be accepted at the edge ending N+2.
- Back-to-back operation: a dispatch presented in the same cycle `data_valid` pulses (`busy`=0) is accepted. Peak throughput is one read per `READ_LATENCY`+2 cycles and one write per 2 cycles.
- Read-after-write to the same address, dispatched the cycle after `busy` drops, returns the new data. No forwarding is needed because the write has already committed.
- A strobe asserted while `busy`=1 is ignored: no error, no state change.

## Test plan
- Reset, then DWORD write 32'hDEADBEEF at 0x10, then DWORD read 0x10 → `busy` high 1 cycle for the write; `data_valid` exactly 4 cycles after the read dispatch with `read_data`=32'hDEADBEEF.
- BYTE writes 0x11, 0x22, 0x33, 0x44 to 0x20..0x23, then:
  - DWORD read 0x20 → 32'h44332211.
  - WORD read 0x22 → 32'h00004433.
  - BYTE read 0x23 → 32'h00000044.
- Misaligned DWORD read at 0x21 → next cycle `access_err`=1, `data_valid`=1, `read_data`=0, `busy` never set; a following read of 0x20 is unchanged.
- Both strobes high at 0x30 → `access_err` pulse, memory at 0x30 unchanged; a strobe asserted while `busy`=1 → ignored, no pulse.
- Assert `rst_in` asynchronously in READ_WAIT → `busy`/`data_valid` drop to 0 immediately, no `data_valid` afterwards, and the next read completes normally.
- Address `BASE_ADDR+DEPTH*4` read → `access_err` pulse with `read_data`=0. Back-to-back: a read dispatched in the same cycle as the previous `data_valid` is accepted.

Source files
------------

// File: rtl/data_memory_responder.sv
// ============================================================================
// data_memory_responder
// ----------------------------------------------------------------------------
// Responder end of the CPU memory_bus load/store interface. The execute stage
// dispatches one read or write at a time. This block checks the request,
// performs a byte / halfword / word access against an internal block-RAM data
// memory, and returns right-justified, zero-extended load data with a one-cycle
// completion pulse. While a request is in flight, busy is held high so the CPU
// stalls its memory stage. There is no queuing: strobes seen while busy are
// dropped.
//
// Parameters
//   DEPTH         data memory size in 32-bit words (power of two, >= 2)
//   READ_LATENCY  block-RAM read pipeline depth in cycles (>= 1)
//   BASE_ADDR     byte address of word 0 (DEPTH*4 aligned)
//
// Ports
//   clk_in          single clock
//   rst_in          asynchronous active-high reset
//   addr            byte address of the request
//   mem_width       access size: 2'b00 byte, 2'b01 halfword, 2'b10 word,
//                   2'b11 unused (always rejected)
//   dispatch_read   load request strobe, sampled while busy is low
//   dispatch_write  store request strobe, sampled while busy is low
//   write_data      store data, right-justified
//   busy            a request is in flight; new strobes are ignored
//   read_data       load result, right-justified, zero-extended; holds its
//                   value until the next load completes
//   data_valid      one-cycle pulse when read_data carries a finished load
//   access_err      one-cycle pulse when a request was rejected
// ============================================================================
module data_memory_responder #(
    parameter int          DEPTH        = 4096,
    parameter int          READ_LATENCY = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] addr,
    input  logic [1:0]  mem_width,
    input  logic        dispatch_read,
    input  logic        dispatch_write,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic [31:0] read_data,
    output logic        data_valid,
    output logic        access_err
);

    // Access size encodings on mem_width.
    localparam logic [1:0] WIDTH_BYTE  = 2'b00;
    localparam logic [1:0] WIDTH_WORD  = 2'b01;
    localparam logic [1:0] WIDTH_DWORD = 2'b10;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_READ_WAIT    = 2'd1;
    localparam logic [1:0] ST_READ_DONE    = 2'd2;
    localparam logic [1:0] ST_WRITE_COMMIT = 2'd3;

    localparam int IDX_W = $clog2(DEPTH);
    // Wide enough to hold READ_LATENCY-1 even when READ_LATENCY is 1.
    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);
    // Size of the mapped window in bytes; 33 bits so a 4 GiB window still fits.
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    logic [1:0]       state;
    logic [CNT_W-1:0] lat_cnt;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lane_q;
    logic [1:0]       width_q;
    logic [31:0]      wdata_q;

    logic [31:0] offset;
    logic        in_range;
    logic        aligned;
    logic        legal;
    logic        in_idle;
    logic        accept_read;
    logic        accept_write;
    logic        reject;

    logic [3:0]  wr_be;
    logic [31:0] wr_word;
    logic        mem_we;
    logic [31:0] rd_word;
    logic [31:0] lane_data;

    logic [31:0] mem_array [DEPTH];
    logic [31:0] rd_pipe   [READ_LATENCY];

    // Decode the incoming request. The window check is done on the byte
    // offset from BASE_ADDR. Addresses below the base wrap to a large offset,
    // so the explicit lower-bound compare keeps them out. The unused width
    // encoding falls through to "not aligned", which rejects it as well.
    always_comb begin
        offset   = addr - BASE_ADDR;
        in_range = (addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
        aligned  = 1'b0;
        case (mem_width)
            WIDTH_BYTE:  aligned = 1'b1;
            WIDTH_WORD:  aligned = ~addr[0];
            WIDTH_DWORD: aligned = (addr[1:0] == 2'b00);
            default:     aligned = 1'b0;
        endcase
        legal        = in_range && aligned && !(dispatch_read && dispatch_write);
        in_idle      = (state == ST_IDLE);
        accept_read  = in_idle && legal && dispatch_read && !dispatch_write;
        accept_write = in_idle && legal && dispatch_write && !dispatch_read;
        reject       = in_idle && !legal && (dispatch_read || dispatch_write);
    end

    assign busy = (state != ST_IDLE);

    // Request FSM. An accepted request latches everything it needs, so the
    // bus inputs are free to change while the access runs. A read spends
    // READ_LATENCY cycles in READ_WAIT while the BRAM pipeline fills. It then
    // spends one cycle in READ_DONE, where the lane is extracted. A write
    // spends a single cycle in WRITE_COMMIT. Because the state resets
    // asynchronously, a reset drops busy at once and cancels any pending
    // commit.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            width_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_read || accept_write) begin
                        idx_q   <= offset[IDX_W+1:2];
                        lane_q  <= addr[1:0];
                        width_q <= mem_width;
                        wdata_q <= write_data;
                    end
                    if (accept_read) begin
                        state   <= ST_READ_WAIT;
                        lat_cnt <= CNT_INIT;
                    end else if (accept_write) begin
                        state   <= ST_WRITE_COMMIT;
                    end
                end
                ST_READ_WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= ST_READ_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_READ_DONE:    state <= ST_IDLE;
                ST_WRITE_COMMIT: state <= ST_IDLE;
                default:         state <= ST_IDLE;
            endcase
        end
    end

    // Store lane steering. Narrow stores replicate their data across the
    // word, and the byte enables pick the lanes that are actually written.
    // Untouched bytes keep their contents, so no read-modify-write is needed.
    always_comb begin
        wr_be   = 4'b1111;
        wr_word = wdata_q;
        case (width_q)
            WIDTH_BYTE: begin
                wr_be   = 4'b0001 << lane_q;
                wr_word = {4{wdata_q[7:0]}};
            end
            WIDTH_WORD: begin
                wr_be   = lane_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_word = wdata_q;
            end
        endcase
    end

    assign mem_we = (state == ST_WRITE_COMMIT);

    // Block-RAM body: a byte-enabled write port plus a registered read whose
    // output passes through READ_LATENCY register stages in total. The read
    // address is the latched index, so the pipeline output is valid exactly
    // when the FSM reaches READ_DONE. There is no reset, so the memory
    // contents survive rst_in.
    always_ff @(posedge clk_in) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && wr_be[b]) begin
                mem_array[idx_q][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
        rd_pipe[0] <= mem_array[idx_q];
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign rd_word = rd_pipe[READ_LATENCY-1];

    // Load lane extraction. The selected byte or halfword is shifted down to
    // bit 0 and zero-extended. The CPU handles sign extension itself.
    always_comb begin
        lane_data = rd_word;
        case (width_q)
            WIDTH_BYTE: begin
                case (lane_q)
                    2'd0:    lane_data = {24'b0, rd_word[7:0]};
                    2'd1:    lane_data = {24'b0, rd_word[15:8]};
                    2'd2:    lane_data = {24'b0, rd_word[23:16]};
                    default: lane_data = {24'b0, rd_word[31:24]};
                endcase
            end
            WIDTH_WORD: begin
                lane_data = lane_q[1] ? {16'b0, rd_word[31:16]} : {16'b0, rd_word[15:0]};
            end
            default: lane_data = rd_word;
        endcase
    end

    // Completion outputs. A finished load pulses data_valid with the
    // extracted lane. A rejected request pulses access_err in the cycle after
    // it was presented. If the rejected request carried a read strobe,
    // data_valid also pulses with zero data, so the CPU is never left waiting.
    // Stores leave read_data alone.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            read_data  <= '0;
            data_valid <= 1'b0;
            access_err <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            access_err <= 1'b0;
            if (state == ST_READ_DONE) begin
                read_data  <= lane_data;
                data_valid <= 1'b1;
            end else if (reject) begin
                access_err <= 1'b1;
                if (dispatch_read) begin
                    read_data  <= '0;
                    data_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// ============================================================================
// tb_data_memory_responder
// ----------------------------------------------------------------------------
// Scoreboard bench for data_memory_responder. The stimulus side keeps a
// byte-array image of the data memory. On every dispatch it decides, from the
// address/width/strobe rules, what the response should be and when it should
// arrive, and queues that expectation. A separate monitor pops the queue
// whenever the DUT pulses data_valid or access_err, and it flags responses
// that are overdue or that were never expected.
// ============================================================================
`timescale 1ns/1ps

module tb_data_memory_responder;

    localparam int          DEPTH = 4096;
    localparam int          RL    = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    localparam logic [1:0] W_BYTE  = 2'b00;
    localparam logic [1:0] W_WORD  = 2'b01;
    localparam logic [1:0] W_DWORD = 2'b10;
    localparam logic [1:0] W_BAD   = 2'b11;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] addr = '0;
    logic [1:0]  mem_width = '0;
    logic        dispatch_read = 1'b0;
    logic        dispatch_write = 1'b0;
    logic [31:0] write_data = '0;
    logic        busy;
    logic [31:0] read_data;
    logic        data_valid;
    logic        access_err;

    typedef struct {
        bit          exp_dv;
        bit          exp_err;
        logic [31:0] exp_data;
        int          exp_cycle;
    } resp_t;

    resp_t       sb_q[$];
    bit [7:0]    ref_mem [0:DEPTH*4-1];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_load = '0;

    data_memory_responder #(
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .addr           (addr),
        .mem_width      (mem_width),
        .dispatch_read  (dispatch_read),
        .dispatch_write (dispatch_write),
        .write_data     (write_data),
        .busy           (busy),
        .read_data      (read_data),
        .data_valid     (data_valid),
        .access_err     (access_err)
    );

    always #5 clk_in = ~clk_in;

    // Count rising edges; read only at falling edges.
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    function automatic int sizeOf(input logic [1:0] w);
        case (w)
            W_BYTE:  return 1;
            W_WORD:  return 2;
            W_DWORD: return 4;
            default: return 0;
        endcase
    endfunction

    // Legality from the access rules: exactly one strobe, a known size,
    // inside the mapped window, and naturally aligned for that size.
    function automatic bit isLegal(input bit rd, input bit wr,
                                   input logic [31:0] a, input logic [1:0] w);
        longint off;
        int     size;
        off  = longint'(a) - longint'(BASE);
        size = sizeOf(w);
        if (rd == wr)                          return 0;
        if (size == 0)                         return 0;
        if (off < 0 || off >= longint'(DEPTH) * 4) return 0;
        if ((off % size) != 0)                 return 0;
        return 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Present one request at a falling edge once busy is low, update the
    // reference image and the scoreboard, and return at the falling edge of
    // the first cycle after dispatch, with busy checked there.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a,
                                 input logic [1:0] w, input logic [31:0] d,
                                 output bit legal);
        int          guard;
        int          off;
        int          size;
        logic [31:0] val;
        resp_t       r;
        guard = 0;
        while (busy === 1'b1 && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        checkOutput("busy_idle_before_dispatch", {31'b0, busy}, 32'd0);
        legal = isLegal(rd, wr, a, w);
        size  = sizeOf(w);
        if (legal) begin
            off = int'(a - BASE);
            if (wr) begin
                for (int k = 0; k < size; k++) ref_mem[off+k] = d[8*k +: 8];
            end else begin
                val = '0;
                for (int k = 0; k < size; k++) val = val | (32'(ref_mem[off+k]) << (8*k));
                r.exp_dv = 1; r.exp_err = 0; r.exp_data = val; r.exp_cycle = cyc + 1 + RL + 1;
                sb_q.push_back(r);
                last_load = val;
            end
        end else begin
            r.exp_dv = rd; r.exp_err = 1; r.exp_data = '0; r.exp_cycle = cyc + 1;
            sb_q.push_back(r);
            if (rd) last_load = '0;
        end
        addr           = a;
        mem_width      = w;
        write_data     = d;
        dispatch_read  = rd;
        dispatch_write = wr;
        @(posedge clk_in);
        @(negedge clk_in);
        dispatch_read  = 1'b0;
        dispatch_write = 1'b0;
        checkOutput("busy_after_dispatch", {31'b0, busy}, {31'b0, legal});
    endtask

    // Full operation. A legal store must leave read_data untouched and
    // release busy after exactly one cycle.
    task automatic doOp(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [1:0] w, input logic [31:0] d);
        bit legal;
        applyStimulus(rd, wr, a, w, d, legal);
        if (legal && wr) begin
            checkOutput("read_data_held_on_store", read_data, last_load);
            @(negedge clk_in);
            checkOutput("write_busy_one_cycle", {31'b0, busy}, 32'd0);
        end
    endtask

    // Pulse reset between clock edges while a request is in flight; the
    // outputs must drop immediately.
    task automatic asyncResetPulse();
        #1 rst_in = 1'b1;
        #1;
        checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("async_reset_dv", {31'b0, data_valid}, 32'd0);
        checkOutput("async_reset_rdata", read_data, 32'd0);
        #1 rst_in = 1'b0;
        last_load = '0;
        repeat (8) @(negedge clk_in);
    endtask

    // Monitor: compare each response pulse with the oldest expectation, and
    // flag expectations whose cycle has passed without a response.
    always @(negedge clk_in) begin
        resp_t r;
        if (!rst_in) begin
            if (data_valid === 1'b1 || access_err === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_response dv=%0b err=%0b data=%h required=none (cycle %0d)",
                             data_valid, access_err, read_data, cyc);
                end else begin
                    r = sb_q.pop_front();
                    checkOutput("resp_cycle", cyc, r.exp_cycle);
                    checkOutput("resp_data_valid", {31'b0, data_valid}, {31'b0, r.exp_dv});
                    checkOutput("resp_access_err", {31'b0, access_err}, {31'b0, r.exp_err});
                    if (r.exp_dv) checkOutput("resp_read_data", read_data, r.exp_data);
                end
            end else if (sb_q.size() > 0 && cyc > sb_q[0].exp_cycle) begin
                r = sb_q.pop_front();
                checkOutput("missing_response_cycle", cyc, r.exp_cycle);
            end
        end
    end

    initial begin
        bit          legal;
        logic [31:0] a;
        logic [1:0]  w;
        int          sel;
        bit [7:0]    saved [4];

        // Reset state
        repeat (3) @(negedge clk_in);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_data_valid", {31'b0, data_valid}, 32'd0);
        checkOutput("reset_access_err", {31'b0, access_err}, 32'd0);
        checkOutput("reset_read_data", read_data, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Word store and load
        doOp(0, 1, 32'h10, W_DWORD, 32'hDEADBEEF);
        doOp(1, 0, 32'h10, W_DWORD, 32'h0);

        // Byte stores, then loads of every width
        doOp(0, 1, 32'h20, W_BYTE, 32'hFFFFFF11);
        doOp(0, 1, 32'h21, W_BYTE, 32'hAAAAAA22);
        doOp(0, 1, 32'h22, W_BYTE, 32'h00000033);
        doOp(0, 1, 32'h23, W_BYTE, 32'h12345644);
        doOp(1, 0, 32'h20, W_DWORD, 32'h0);
        doOp(1, 0, 32'h22, W_WORD, 32'h0);
        doOp(1, 0, 32'h23, W_BYTE, 32'h0);

        // Rejected requests: misaligned, unused width, odd halfword store
        doOp(1, 0, 32'h21, W_DWORD, 32'h0);
        doOp(1, 0, 32'h20, W_DWORD, 32'h0);
        doOp(1, 0, 32'h20, W_BAD, 32'h0);
        doOp(0, 1, 32'h21, W_WORD, 32'hFFFF_FFFF);
        doOp(1, 0, 32'h20, W_DWORD, 32'h0);

        // Both strobes together, then a strobe while busy
        doOp(0, 1, 32'h30, W_DWORD, 32'h0A0B0C0D);
        doOp(1, 1, 32'h30, W_DWORD, 32'h99999999);
        applyStimulus(1, 0, 32'h30, W_DWORD, 32'h0, legal);
        dispatch_write = 1'b1;
        addr           = 32'h30;
        mem_width      = W_DWORD;
        write_data     = 32'hBAD0BAD0;
        @(negedge clk_in);
        dispatch_write = 1'b0;
        doOp(1, 0, 32'h30, W_DWORD, 32'h0);

        // Window edges
        doOp(1, 0, BASE + DEPTH*4, W_DWORD, 32'h0);
        doOp(0, 1, 32'hFFFF_FFFC, W_DWORD, 32'h1);
        doOp(0, 1, BASE + DEPTH*4 - 4, W_DWORD, 32'h5566_7788);
        doOp(1, 0, BASE + DEPTH*4 - 3, W_BYTE, 32'h0);

        // Back-to-back reads: the second one goes out in the data_valid cycle
        doOp(1, 0, 32'h10, W_DWORD, 32'h0);
        while (busy === 1'b1) @(negedge clk_in);
        checkOutput("b2b_dispatch_in_dv_cycle", {31'b0, data_valid}, 32'd1);
        doOp(1, 0, 32'h20, W_WORD, 32'h0);

        // Reset in READ_WAIT: the read is discarded and nothing completes
        applyStimulus(1, 0, 32'h10, W_DWORD, 32'h0, legal);
        void'(sb_q.pop_back());
        asyncResetPulse();
        doOp(1, 0, 32'h10, W_DWORD, 32'h0);

        // Reset in WRITE_COMMIT: the store is cancelled
        doOp(0, 1, 32'h40, W_DWORD, 32'h12345678);
        for (int k = 0; k < 4; k++) saved[k] = ref_mem[32'h40 + k];
        applyStimulus(0, 1, 32'h40, W_DWORD, 32'hCAFEF00D, legal);
        for (int k = 0; k < 4; k++) ref_mem[32'h40 + k] = saved[k];
        asyncResetPulse();
        doOp(1, 0, 32'h40, W_DWORD, 32'h0);

        // Randomized traffic over a small, fully initialised window
        for (int i = 0; i < 16; i++) doOp(0, 1, 32'h100 + 32'(4*i), W_DWORD, $urandom());
        for (int i = 0; i < 250; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) == 0) ? (BASE + DEPTH*4 + 32'($urandom_range(0, 7))) : 32'hFFFF_FFF0;
            w   = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 9));
            if (sel == 0)     doOp(1, 1, a, w, $urandom());
            else if (sel < 6) doOp(1, 0, a, w, 32'h0);
            else              doOp(0, 1, a, w, $urandom());
        end

        // Drain outstanding responses
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk_in);
        checkOutput("scoreboard_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
